// File: rtl/square_motion_ctrl.sv
// square_motion_ctrl
//   Per-frame jump/gravity physics for the square's vertical position. All physics state
//   advances only on frame_tick with pause low, so square_y is stable across active video.
//
// Ports
//   clk          pixel clock
//   rst_n        asynchronous reset, active low
//   frame_tick   one-cycle pulse at the start of vertical blank
//   jump         jump button level (synchronised, debounced)
//   pause        freezes the physics while high
//   square_size  square edge length in pixels
//   square_y     top edge of the square (registered)
//   vel          signed velocity in pixels/frame, downward positive (registered)
//   on_floor     high while the square rests on the floor (registered)
//   hit_ceil     one-cycle pulse after the tick on which the ceiling clamp occurred

module square_motion_ctrl #(
    parameter int COORD_W  = 10,
    parameter int SIZE_W   = 6,
    parameter int VEL_W    = 8,
    parameter int SCREEN_H = 480,
    parameter int Y_INIT   = 200,
    parameter int GRAVITY  = 1,
    parameter int JUMP_V   = -9,
    parameter int VMAX     = 12
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    frame_tick,
    input  logic                    jump,
    input  logic                    pause,
    input  logic [SIZE_W-1:0]       square_size,
    output logic [COORD_W-1:0]      square_y,
    output logic signed [VEL_W-1:0] vel,
    output logic                    on_floor,
    output logic                    hit_ceil
);

    localparam int YW = COORD_W + 2;

    localparam logic signed [VEL_W-1:0] JumpVel = VEL_W'(JUMP_V);
    localparam logic signed [VEL_W-1:0] VmaxVel = VEL_W'(VMAX);
    localparam logic signed [VEL_W:0]   GravExt = (VEL_W + 1)'(GRAVITY);
    localparam logic signed [VEL_W:0]   VmaxExt = (VEL_W + 1)'(VMAX);
    localparam logic signed [YW-1:0]    ScreenH = YW'(SCREEN_H);
    localparam logic [COORD_W-1:0]      YInit   = COORD_W'(Y_INIT);

    typedef enum logic [1:0] {StIdle, StAir, StGround} state_e;

    state_e                    state_q, state_d;
    logic [COORD_W-1:0]        y_q, y_d;
    logic signed [VEL_W-1:0]   vel_q, vel_d;
    logic                      on_floor_q, on_floor_d;
    logic                      hit_ceil_q, hit_ceil_d;
    logic                      jump_q;
    logic                      jump_pend_q, jump_pend_d;

    logic                      jump_rise;
    logic                      step;
    logic signed [VEL_W:0]     vel_sum;
    logic signed [VEL_W-1:0]   vel_grav;
    logic signed [VEL_W-1:0]   vel_n;
    logic signed [YW-1:0]      y_n;
    logic signed [YW-1:0]      floor_lim;

    assign jump_rise = jump & ~jump_q;
    assign step      = frame_tick & ~pause;

    // One extra bit so VEL+GRAVITY cannot wrap before the terminal-velocity clamp.
    assign vel_sum  = $signed({vel_q[VEL_W-1], vel_q}) + GravExt;
    assign vel_grav = (vel_sum > VmaxExt) ? VmaxVel : vel_sum[VEL_W-1:0];
    assign vel_n    = jump_pend_q ? JumpVel : vel_grav;

    // Two guard bits: y_n may go negative or past the screen without wrapping.
    assign y_n       = $signed({2'b00, y_q}) + $signed({{(YW - VEL_W){vel_n[VEL_W-1]}}, vel_n});
    assign floor_lim = ScreenH - $signed({{(YW - SIZE_W){1'b0}}, square_size});

    always_comb begin
        state_d     = state_q;
        y_d         = y_q;
        vel_d       = vel_q;
        on_floor_d  = on_floor_q;
        hit_ceil_d  = 1'b0;
        jump_pend_d = jump_pend_q;

        if (step) begin
            // The tick always consumes the pending jump, used or not.
            jump_pend_d = 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (jump_pend_q) begin
                        vel_d   = JumpVel;
                        state_d = StAir;
                    end
                end
                StAir: begin
                    // Floor first: with a tiny play field both limits can be hit at once.
                    if (y_n >= floor_lim) begin
                        y_d        = floor_lim[COORD_W-1:0];
                        vel_d      = '0;
                        on_floor_d = 1'b1;
                        state_d    = StGround;
                    end else if (y_n[YW-1] || (y_n == '0)) begin
                        y_d        = '0;
                        vel_d      = '0;
                        hit_ceil_d = 1'b1;
                    end else begin
                        y_d   = y_n[COORD_W-1:0];
                        vel_d = vel_n;
                    end
                end
                StGround: begin
                    // Re-clamp so a square_size change moves the resting square.
                    y_d        = floor_lim[COORD_W-1:0];
                    on_floor_d = 1'b1;
                    if (jump_pend_q) begin
                        vel_d      = JumpVel;
                        on_floor_d = 1'b0;
                        state_d    = StAir;
                    end
                end
                default: state_d = StIdle;
            endcase
        end

        // A same-cycle edge is latched after the tick used the old pending flag.
        if (jump_rise && !pause) begin
            jump_pend_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            y_q         <= YInit;
            vel_q       <= '0;
            on_floor_q  <= 1'b0;
            hit_ceil_q  <= 1'b0;
            jump_q      <= 1'b0;
            jump_pend_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            y_q         <= y_d;
            vel_q       <= vel_d;
            on_floor_q  <= on_floor_d;
            hit_ceil_q  <= hit_ceil_d;
            jump_q      <= jump;
            jump_pend_q <= jump_pend_d;
        end
    end

    assign square_y = y_q;
    assign vel      = vel_q;
    assign on_floor = on_floor_q;
    assign hit_ceil = hit_ceil_q;

endmodule

// File: tb/tb_square_motion_ctrl.sv
// tb_square_motion_ctrl
//   Scoreboard bench for square_motion_ctrl: each driven tick pushes the expected outputs from
//   a behavioural model; test tasks pop and compare once the DUT has registered the update.

module tb_square_motion_ctrl;

    typedef struct packed {
        logic [9:0] y;
        logic [7:0] v;
        logic       fl;
        logic       hc;
    } exp_t;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              frame_tick;
    logic              jump;
    logic              pause;
    logic [5:0]        square_size;
    logic [9:0]        square_y;
    logic signed [7:0] vel;
    logic              on_floor;
    logic              hit_ceil;

    exp_t sb[$];
    int   total  = 0;
    int   passed = 0;

    // Behavioural model state (0 idle, 1 air, 2 ground)
    int m_y, m_vel, m_st;
    bit m_fl, m_pend, m_jq;

    square_motion_ctrl dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .frame_tick  (frame_tick),
        .jump        (jump),
        .pause       (pause),
        .square_size (square_size),
        .square_y    (square_y),
        .vel         (vel),
        .on_floor    (on_floor),
        .hit_ceil    (hit_ceil)
    );

    always #5 clk = ~clk;

    task automatic model_reset();
        m_y = 200; m_vel = 0; m_st = 0; m_fl = 0; m_pend = 0; m_jq = 0;
        sb.delete();
    endtask

    // One clock cycle of stimulus; a tick pushes the model's expected outputs.
    task automatic cycle(input bit tk, input bit jp, input bit ps);
        exp_t e;
        int   vn, yn, lim;
        bit   hc, rise;
        @(negedge clk);
        frame_tick = tk; jump = jp; pause = ps;
        rise = jp && !m_jq;
        hc = 0;
        if (tk && !ps) begin
            lim = 480 - int'(square_size);
            if (m_st == 0) begin
                if (m_pend) begin m_vel = -9; m_st = 1; end
            end else if (m_st == 2) begin
                m_y = lim;
                if (m_pend) begin m_vel = -9; m_fl = 0; m_st = 1; end
            end else begin
                vn = m_pend ? -9 : ((m_vel + 1 > 12) ? 12 : m_vel + 1);
                yn = m_y + vn;
                if (yn >= lim) begin
                    m_y = lim; m_vel = 0; m_fl = 1; m_st = 2;
                end else if (yn <= 0) begin
                    m_y = 0; m_vel = 0; hc = 1;
                end else begin
                    m_y = yn; m_vel = vn;
                end
            end
            m_pend = 0;
        end
        if (rise && !ps) m_pend = 1;
        m_jq = jp;
        if (tk) begin
            e.y = 10'(m_y); e.v = 8'(m_vel); e.fl = m_fl; e.hc = hc;
            sb.push_back(e);
        end
        @(posedge clk);
        #1;
        frame_tick = 1'b0;
    endtask

    task automatic apply_reset();
        rst_n = 1'b0; frame_tick = 1'b0; jump = 1'b0; pause = 1'b0;
        model_reset();
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        exp_t e;
        square_size = 6'd20;
        apply_reset();
        total++;
        if ({square_y, vel, on_floor, hit_ceil} !== {10'd200, 8'sd0, 1'b0, 1'b0})
            $display("FAIL reset_vals: got y=%0d vel=%0d fl=%b hc=%b want y=200 vel=0 fl=0 hc=0",
                     square_y, vel, on_floor, hit_ceil);
        else passed++;
        repeat (5) cycle(0, 0, 0);
        total++;
        if ({square_y, vel, on_floor} !== {10'd200, 8'sd0, 1'b0})
            $display("FAIL reset_idle_hold: got y=%0d vel=%0d fl=%b want y=200 vel=0 fl=0",
                     square_y, vel, on_floor);
        else passed++;
        // A tick without a pending jump leaves the hovering square alone.
        cycle(1, 0, 0);
        e = sb.pop_front();
        total++;
        if ({square_y, vel, on_floor, hit_ceil} !== e)
            $display("FAIL idle_tick: got y=%0d vel=%0d fl=%b hc=%b want y=%0d vel=%0d fl=%b hc=%b",
                     square_y, vel, on_floor, hit_ceil, e.y, $signed(e.v), e.fl, e.hc);
        else passed++;
    endtask

    task automatic test_jump();
        exp_t e;
        logic [9:0]        want_y[3];
        logic signed [7:0] want_v[3];
        want_y[0] = 10'd200; want_y[1] = 10'd192; want_y[2] = 10'd185;
        want_v[0] = -8'sd9;  want_v[1] = -8'sd8;  want_v[2] = -8'sd7;
        cycle(0, 1, 0);
        cycle(0, 0, 0);
        for (int i = 0; i < 3; i++) begin
            cycle(1, 0, 0);
            e = sb.pop_front();
            total++;
            if ({square_y, vel, on_floor, hit_ceil} !== e)
                $display("FAIL jump_sb%0d: got y=%0d vel=%0d fl=%b hc=%b want y=%0d vel=%0d fl=%b hc=%b",
                         i, square_y, vel, on_floor, hit_ceil, e.y, $signed(e.v), e.fl, e.hc);
            else passed++;
            total++;
            if (square_y !== want_y[i] || vel !== want_v[i])
                $display("FAIL jump_trace%0d: got y=%0d vel=%0d want y=%0d vel=%0d",
                         i, square_y, vel, want_y[i], want_v[i]);
            else passed++;
        end
        // Repeated mid-air jumps climb 9 lines per tick: 185 -> 5.
        for (int i = 0; i < 20; i++) begin
            cycle(0, 1, 0);
            cycle(0, 0, 0);
            cycle(1, 0, 0);
            e = sb.pop_front();
            total++;
            if ({square_y, vel, on_floor, hit_ceil} !== e)
                $display("FAIL midair_sb%0d: got y=%0d vel=%0d fl=%b hc=%b want y=%0d vel=%0d fl=%b hc=%b",
                         i, square_y, vel, on_floor, hit_ceil, e.y, $signed(e.v), e.fl, e.hc);
            else passed++;
        end
        total++;
        if (square_y !== 10'd5 || vel !== -8'sd9)
            $display("FAIL midair_final: got y=%0d vel=%0d want y=5 vel=-9", square_y, vel);
        else passed++;
    endtask

    task automatic test_ceiling();
        exp_t e;
        cycle(1, 0, 0);
        e = sb.pop_front();
        total++;
        if ({square_y, vel, on_floor, hit_ceil} !== e)
            $display("FAIL ceil_sb: got y=%0d vel=%0d fl=%b hc=%b want y=%0d vel=%0d fl=%b hc=%b",
                     square_y, vel, on_floor, hit_ceil, e.y, $signed(e.v), e.fl, e.hc);
        else passed++;
        total++;
        if ({square_y, vel, hit_ceil} !== {10'd0, 8'sd0, 1'b1})
            $display("FAIL ceil_clamp: got y=%0d vel=%0d hc=%b want y=0 vel=0 hc=1",
                     square_y, vel, hit_ceil);
        else passed++;
        cycle(0, 0, 0);
        total++;
        if (hit_ceil !== 1'b0)
            $display("FAIL ceil_pulse_width: got hc=%b want hc=0", hit_ceil);
        else passed++;
    endtask

    task automatic test_pause();
        exp_t e;
        for (int i = 0; i < 3; i++) begin
            cycle(1, 0, 0);
            e = sb.pop_front();
            total++;
            if ({square_y, vel, on_floor, hit_ceil} !== e)
                $display("FAIL prepause_sb%0d: got y=%0d vel=%0d fl=%b hc=%b want y=%0d vel=%0d fl=%b hc=%b",
                         i, square_y, vel, on_floor, hit_ceil, e.y, $signed(e.v), e.fl, e.hc);
            else passed++;
        end
        // Ten paused ticks; a jump edge arrives in the middle and must be dropped.
        for (int i = 0; i < 10; i++) begin
            if (i == 3) cycle(0, 1, 1);
            if (i == 6) cycle(0, 0, 1);
            cycle(1, (i >= 3 && i < 6), 1);
            e = sb.pop_front();
            total++;
            if ({square_y, vel, on_floor, hit_ceil} !== e ||
                square_y !== 10'd6 || vel !== 8'sd3)
                $display("FAIL pause_hold%0d: got y=%0d vel=%0d fl=%b hc=%b want y=%0d vel=%0d fl=%b hc=%b",
                         i, square_y, vel, on_floor, hit_ceil, e.y, $signed(e.v), e.fl, e.hc);
            else passed++;
        end
        cycle(1, 0, 0);
        e = sb.pop_front();
        total++;
        if ({square_y, vel, on_floor, hit_ceil} !== e || square_y !== 10'd10 || vel !== 8'sd4)
            $display("FAIL pause_resume: got y=%0d vel=%0d fl=%b hc=%b want y=10 vel=4 fl=%b hc=%b",
                     square_y, vel, on_floor, hit_ceil, e.fl, e.hc);
        else passed++;
    endtask

    task automatic test_back_to_back();
        exp_t e;
        // Tick and edge together: the tick sees no pending jump, the next tick applies it.
        cycle(1, 1, 0);
        e = sb.pop_front();
        total++;
        if ({square_y, vel, on_floor, hit_ceil} !== e || vel !== 8'sd5)
            $display("FAIL b2b_first: got y=%0d vel=%0d fl=%b hc=%b want y=%0d vel=%0d fl=%b hc=%b",
                     square_y, vel, on_floor, hit_ceil, e.y, $signed(e.v), e.fl, e.hc);
        else passed++;
        cycle(0, 0, 0);
        cycle(1, 0, 0);
        e = sb.pop_front();
        total++;
        if ({square_y, vel, on_floor, hit_ceil} !== e || square_y !== 10'd6 || vel !== -8'sd9)
            $display("FAIL b2b_second: got y=%0d vel=%0d fl=%b hc=%b want y=6 vel=-9 fl=%b hc=%b",
                     square_y, vel, on_floor, hit_ceil, e.fl, e.hc);
        else passed++;
    endtask

    task automatic test_reset_mid_air();
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        total++;
        if ({square_y, vel, on_floor, hit_ceil} !== {10'd200, 8'sd0, 1'b0, 1'b0})
            $display("FAIL async_reset: got y=%0d vel=%0d fl=%b hc=%b want y=200 vel=0 fl=0 hc=0",
                     square_y, vel, on_floor, hit_ceil);
        else passed++;
    endtask

    task automatic test_saturation_floor();
        exp_t e;
        int   max_vel = -128;
        apply_reset();
        cycle(0, 1, 0);
        for (int i = 0; i < 100; i++) begin
            cycle(1, 1, 0);
            e = sb.pop_front();
            if (int'(vel) > max_vel) max_vel = int'(vel);
            total++;
            if ({square_y, vel, on_floor, hit_ceil} !== e)
                $display("FAIL held_sb%0d: got y=%0d vel=%0d fl=%b hc=%b want y=%0d vel=%0d fl=%b hc=%b",
                         i, square_y, vel, on_floor, hit_ceil, e.y, $signed(e.v), e.fl, e.hc);
            else passed++;
        end
        total++;
        if (max_vel != 12)
            $display("FAIL vmax_sat: got max vel=%0d want 12", max_vel);
        else passed++;
        total++;
        if ({square_y, vel, on_floor} !== {10'd460, 8'sd0, 1'b1})
            $display("FAIL floor_land: got y=%0d vel=%0d fl=%b want y=460 vel=0 fl=1",
                     square_y, vel, on_floor);
        else passed++;
    endtask

    task automatic test_size_change_and_ground_jump();
        exp_t e;
        cycle(0, 0, 0);
        square_size = 6'd40;
        cycle(1, 0, 0);
        e = sb.pop_front();
        total++;
        if ({square_y, vel, on_floor, hit_ceil} !== e || square_y !== 10'd440 || on_floor !== 1'b1)
            $display("FAIL size_reclamp: got y=%0d vel=%0d fl=%b hc=%b want y=440 vel=0 fl=1 hc=%b",
                     square_y, vel, on_floor, hit_ceil, e.hc);
        else passed++;
        cycle(0, 1, 0);
        cycle(0, 0, 0);
        cycle(1, 0, 0);
        e = sb.pop_front();
        total++;
        if ({square_y, vel, on_floor, hit_ceil} !== e || vel !== -8'sd9 || on_floor !== 1'b0)
            $display("FAIL ground_jump: got y=%0d vel=%0d fl=%b hc=%b want y=%0d vel=-9 fl=0 hc=%b",
                     square_y, vel, on_floor, hit_ceil, e.y, e.hc);
        else passed++;
        cycle(1, 0, 0);
        e = sb.pop_front();
        total++;
        if ({square_y, vel, on_floor, hit_ceil} !== e || square_y !== 10'd432)
            $display("FAIL ground_jump_rise: got y=%0d vel=%0d fl=%b hc=%b want y=432 vel=%0d fl=%b hc=%b",
                     square_y, vel, on_floor, hit_ceil, $signed(e.v), e.fl, e.hc);
        else passed++;
    endtask

    initial begin
        rst_n = 1'b0; frame_tick = 1'b0; jump = 1'b0; pause = 1'b0; square_size = 6'd20;
        test_reset();
        test_jump();
        test_ceiling();
        test_pause();
        test_back_to_back();
        test_reset_mid_air();
        test_saturation_floor();
        test_size_change_and_ground_jump();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
